// File: rtl/arc4_pkg.sv
// -----------------------------------------------------------------------------
// arc4_pkg
// Shared types and constants for the ARC4 double-lane key cracker.
//   - top_state_e  : controller states (IDLE, LOAD, ROUND, CHECK)
//   - lane_state_e : per-lane ARC4 engine states (L_INIT, L_KSA, L_PRGA, L_DONE)
//   - KEY_W / KEY_BYTES : candidate key geometry (key[23:16] is key byte 0)
//   - PRINT_LO / PRINT_HI : accepted plaintext byte range
// -----------------------------------------------------------------------------
package arc4_pkg;

   localparam int KEY_W     = 24;
   localparam int KEY_BYTES = 3;

   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   // Highest candidate, and the last lane-A value for which no further round exists
   localparam logic [KEY_W-1:0] KEY_MAX       = 24'hFFFFFF;
   localparam logic [KEY_W-1:0] KEY_LAST_PAIR = 24'hFFFFFE;

   typedef enum logic [1:0] {IDLE, LOAD, ROUND, CHECK} top_state_e;
   typedef enum logic [1:0] {L_INIT, L_KSA, L_PRGA, L_DONE} lane_state_e;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= PRINT_LO) && (b <= PRINT_HI);
   endfunction

   // Key byte used by KSA iteration i, selected by i mod 3
   function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] key,
                                           input logic [1:0]       idx);
      logic [7:0] kb;
      case (idx)
         2'd0:    kb = key[23:16];
         2'd1:    kb = key[15:8];
         2'd2:    kb = key[7:0];
         default: kb = 8'h00;
      endcase
      return kb;
   endfunction

endpackage

// File: rtl/arc4_doublecrack_if.sv
// -----------------------------------------------------------------------------
// arc4_doublecrack_if
// Controller handshake and ct memory read port of the cracker.
//   en        : start request (controller -> cracker)
//   rdy       : cracker idle, able to accept en
//   key       : cracked key, valid when key_valid=1
//   key_valid : last search found a key
//   ct_addr   : ct memory read address (cracker -> memory)
//   ct_rddata : ct memory data, one cycle after ct_addr (memory -> cracker)
// modport master : controller / memory side; modport slave : cracker side.
// -----------------------------------------------------------------------------
interface arc4_doublecrack_if;
   import arc4_pkg::*;

   logic             en;
   logic             rdy;
   logic [KEY_W-1:0] key;
   logic             key_valid;
   logic [7:0]       ct_addr;
   logic [7:0]       ct_rddata;

   modport master (output en, output ct_rddata,
                   input  rdy, input key, input key_valid, input ct_addr);

   modport slave  (input  en, input ct_rddata,
                   output rdy, output key, output key_valid, output ct_addr);

endinterface

// File: rtl/arc4_doublecrack_lane.sv
// -----------------------------------------------------------------------------
// arc4_lane
// One ARC4 key-test engine: initialises S, runs the 256-step KSA with the
// candidate key, then decrypts the L buffered ciphertext bytes and judges
// whether every plaintext byte is printable.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : one-cycle pulse starting a new test (overrides any activity)
//   enable_i     : sampled with start_i; 0 makes the lane report done/no-pass
//   key_i        : candidate key, held stable by the controller for the round
//   len_i        : message length L
//   buf_addr_o   : read address into the shared ciphertext buffer
//   buf_data_i   : buffer data at buf_addr_o (combinational read)
//   done_o       : test finished
//   pass_o       : all L plaintext bytes were printable (valid with done_o)
// Build option: DOUBLECRACK_EARLY_ABORT_EN stops at the first bad byte;
// otherwise all L bytes are decrypted before judging. Results are identical.
// -----------------------------------------------------------------------------
module arc4_lane
   import arc4_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             enable_i,
   input  logic [KEY_W-1:0] key_i,
   input  logic [7:0]       len_i,
   output logic [7:0]       buf_addr_o,
   input  logic [7:0]       buf_data_i,
   output logic             done_o,
   output logic             pass_o
);

   lane_state_e state_q, state_d;
   logic [7:0]  s_q [256];
   logic [7:0]  s_d [256];
   logic [7:0]  i_q, i_d;
   logic [7:0]  j_q, j_d;
   logic [7:0]  k_q, k_d;
   logic [1:0]  m3_q, m3_d;
   logic        fail_q, fail_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;

   logic [7:0]  ksa_j_s;
   logic [7:0]  i1_s, si_s, j1_s, sj_s, t_s, ks_s, pt_s;
   logic        bad_s;
   logic        last_s;

   // Datapath: KSA j update and one PRGA byte (swap + keystream) per cycle
   always_comb begin
      ksa_j_s = j_q + s_q[i_q] + key_byte(key_i, m3_q);
      i1_s    = i_q + 8'd1;
      si_s    = s_q[i1_s];
      j1_s    = j_q + si_s;
      sj_s    = s_q[j1_s];
      t_s     = si_s + sj_s;
      // Keystream is read from S after the swap, so forward the swapped values
      if (t_s == j1_s) begin
         ks_s = si_s;
      end else if (t_s == i1_s) begin
         ks_s = sj_s;
      end else begin
         ks_s = s_q[t_s];
      end
      buf_addr_o = k_q + 8'd1;
      pt_s       = buf_data_i ^ ks_s;
      bad_s      = !is_printable(pt_s);
      last_s     = (({1'b0, k_q} + 9'd1) == {1'b0, len_i});
   end

   // Lane next-state logic
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      m3_d    = m3_q;
      fail_d  = fail_q;
      done_d  = done_q;
      pass_d  = pass_q;
      if (start_i) begin
         if (enable_i) begin
            state_d = L_INIT;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end else begin
            state_d = L_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b0;
         end
      end else begin
         case (state_q)
            L_INIT: begin
               for (int n = 0; n < 256; n++) begin
                  s_d[n] = 8'(n);
               end
               i_d     = 8'd0;
               j_d     = 8'd0;
               m3_d    = 2'd0;
               state_d = L_KSA;
            end
            L_KSA: begin
               s_d[i_q]     = s_q[ksa_j_s];
               s_d[ksa_j_s] = s_q[i_q];
               j_d          = ksa_j_s;
               i_d          = i_q + 8'd1;
               m3_d         = (m3_q == 2'(KEY_BYTES - 1)) ? 2'd0 : (m3_q + 2'd1);
               if (i_q == 8'hFF) begin
                  state_d = L_PRGA;
                  i_d     = 8'd0;
                  j_d     = 8'd0;
                  k_d     = 8'd0;
                  fail_d  = 1'b0;
               end else begin
                  state_d = L_KSA;
               end
            end
            L_PRGA: begin
               if (len_i == 8'd0) begin
                  // Empty message: nothing can be non-printable
                  state_d = L_DONE;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end else begin
                  s_d[i1_s] = sj_s;
                  s_d[j1_s] = si_s;
                  i_d       = i1_s;
                  j_d       = j1_s;
                  k_d       = k_q + 8'd1;
`ifdef DOUBLECRACK_EARLY_ABORT_EN
                  if (bad_s) begin
                     state_d = L_DONE;
                     done_d  = 1'b1;
                     pass_d  = 1'b0;
                  end else if (last_s) begin
                     state_d = L_DONE;
                     done_d  = 1'b1;
                     pass_d  = 1'b1;
                  end else begin
                     state_d = L_PRGA;
                  end
`else
                  fail_d = fail_q | bad_s;
                  if (last_s) begin
                     state_d = L_DONE;
                     done_d  = 1'b1;
                     pass_d  = !(fail_q | bad_s);
                  end else begin
                     state_d = L_PRGA;
                  end
`endif
               end
            end
            L_DONE: begin
               state_d = L_DONE;
            end
            default: begin
               state_d = L_DONE;
            end
         endcase
      end
   end

   // Lane control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= L_DONE;
         i_q     <= 8'd0;
         j_q     <= 8'd0;
         k_q     <= 8'd0;
         m3_q    <= 2'd0;
         fail_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         m3_q    <= m3_d;
         fail_q  <= fail_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   // S array storage; always rebuilt in L_INIT before use, so no reset
   always_ff @(posedge clk) begin
      s_q <= s_d;
   end

   assign done_o = done_q;
   assign pass_o = pass_q;

endmodule

// File: rtl/arc4_doublecrack.sv
// -----------------------------------------------------------------------------
// arc4_doublecrack
// Brute-forces the 24-bit ARC4 key of a length-prefixed ciphertext. The
// ciphertext is copied once into an internal buffer, then two arc4_lane
// engines test candidates key_attempt_c1 (even) and key_attempt_c1+1 (odd)
// per round. The lowest passing key is reported; exhausting the key space
// reports key_valid=0 with key unchanged.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : arc4_doublecrack_if.slave (en/rdy handshake, key/key_valid result,
//          ct_addr/ct_rddata memory read port, data one cycle after address)
// Build option: DOUBLECRACK_EARLY_ABORT_EN (see arc4_lane) only changes
// round latency.
// -----------------------------------------------------------------------------
module arc4_doublecrack
   import arc4_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   arc4_doublecrack_if.slave       bus
);

   top_state_e       state_q, state_d;
   logic             rdy_q, rdy_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             kv_q, kv_d;
   logic [7:0]       ct_addr_q, ct_addr_d;
   logic [7:0]       len_q, len_d;
   logic             dv_q, dv_d;       // ct_rddata holds data for didx_q
   logic [7:0]       didx_q, didx_d;
   logic             start_q, start_d;

   // Base candidate; kept as a plain register so it can be forced from outside
   logic [KEY_W-1:0] key_attempt_c1;
   logic [KEY_W-1:0] key_attempt_c1_d;

   logic [7:0]       buf_q [256];
   logic             buf_we_s;
   logic             fin_s;

   logic [7:0]       a_addr_s, b_addr_s;
   logic [7:0]       a_data_s, b_data_s;
   logic             a_done_s, a_pass_s, b_done_s, b_pass_s;
   logic             b_en_s;
   logic [KEY_W-1:0] b_key_s;

   // Lane B candidate and its enable (idle when it would exceed the key space)
   always_comb begin
      b_key_s  = key_attempt_c1 + 24'd1;
      b_en_s   = (key_attempt_c1 != KEY_MAX);
      a_data_s = buf_q[a_addr_s];
      b_data_s = buf_q[b_addr_s];
   end

   // Controller next-state and output logic
   always_comb begin
      state_d          = state_q;
      rdy_d            = rdy_q;
      key_d            = key_q;
      kv_d             = kv_q;
      ct_addr_d        = ct_addr_q;
      len_d            = len_q;
      dv_d             = 1'b0;
      didx_d           = ct_addr_q;
      start_d          = 1'b0;
      buf_we_s         = 1'b0;
      fin_s            = 1'b0;
      key_attempt_c1_d = key_attempt_c1;
      case (state_q)
         IDLE: begin
            if (bus.en) begin
               state_d          = LOAD;
               rdy_d            = 1'b0;
               kv_d             = 1'b0;
               ct_addr_d        = 8'd0;
               key_attempt_c1_d = 24'd0;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            // Issue one address per cycle; data lands one cycle later
            ct_addr_d = ct_addr_q + 8'd1;
            dv_d      = 1'b1;
            if (dv_q) begin
               buf_we_s = 1'b1;
               if (didx_q == 8'd0) begin
                  len_d = bus.ct_rddata;
                  fin_s = (bus.ct_rddata == 8'd0);
               end else begin
                  fin_s = (didx_q == len_q);
               end
            end else begin
               fin_s = 1'b0;
            end
            if (fin_s) begin
               state_d = ROUND;
               start_d = 1'b1;
               dv_d    = 1'b0;
            end else begin
               state_d = LOAD;
            end
         end
         ROUND: begin
            // Lane done flags are stale during the start cycle
            if (!start_q && a_done_s && b_done_s) begin
               state_d = CHECK;
            end else begin
               state_d = ROUND;
            end
         end
         CHECK: begin
            if (a_pass_s) begin
               key_d   = key_attempt_c1;
               kv_d    = 1'b1;
               rdy_d   = 1'b1;
               state_d = IDLE;
            end else if (b_pass_s) begin
               key_d   = b_key_s;
               kv_d    = 1'b1;
               rdy_d   = 1'b1;
               state_d = IDLE;
            end else if (key_attempt_c1 >= KEY_LAST_PAIR) begin
               kv_d    = 1'b0;
               rdy_d   = 1'b1;
               state_d = IDLE;
            end else begin
               key_attempt_c1_d = key_attempt_c1 + 24'd2;
               start_d          = 1'b1;
               state_d          = ROUND;
            end
         end
         default: begin
            state_d = IDLE;
            rdy_d   = 1'b1;
         end
      endcase
   end

   // Controller registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         rdy_q          <= 1'b1;
         key_q          <= 24'd0;
         kv_q           <= 1'b0;
         ct_addr_q      <= 8'd0;
         len_q          <= 8'd0;
         dv_q           <= 1'b0;
         didx_q         <= 8'd0;
         start_q        <= 1'b0;
         key_attempt_c1 <= 24'd0;
      end else begin
         state_q        <= state_d;
         rdy_q          <= rdy_d;
         key_q          <= key_d;
         kv_q           <= kv_d;
         ct_addr_q      <= ct_addr_d;
         len_q          <= len_d;
         dv_q           <= dv_d;
         didx_q         <= didx_d;
         start_q        <= start_d;
         key_attempt_c1 <= key_attempt_c1_d;
      end
   end

   // Ciphertext buffer, indexed by ct address (entry 0 holds L)
   always_ff @(posedge clk) begin
      if (buf_we_s) begin
         buf_q[didx_q] <= bus.ct_rddata;
      end
   end

   arc4_lane u_lane_a (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_q),
      .enable_i   (1'b1),
      .key_i      (key_attempt_c1),
      .len_i      (len_q),
      .buf_addr_o (a_addr_s),
      .buf_data_i (a_data_s),
      .done_o     (a_done_s),
      .pass_o     (a_pass_s)
   );

   arc4_lane u_lane_b (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_q),
      .enable_i   (b_en_s),
      .key_i      (b_key_s),
      .len_i      (len_q),
      .buf_addr_o (b_addr_s),
      .buf_data_i (b_data_s),
      .done_o     (b_done_s),
      .pass_o     (b_pass_s)
   );

   assign bus.rdy       = rdy_q;
   assign bus.key       = key_q;
   assign bus.key_valid = kv_q;
   assign bus.ct_addr   = ct_addr_q;

endmodule

// File: tb/tb_arc4_doublecrack.sv
// -----------------------------------------------------------------------------
// tb_arc4_doublecrack
// Directed + randomized bench for arc4_doublecrack. A plain software ARC4
// model computes ciphertexts and the lowest key whose decryption is all
// printable; the DUT result is compared against that.
// -----------------------------------------------------------------------------
module tb_arc4_doublecrack;

   logic clk;
   logic rst;
   arc4_doublecrack_if bus();

   arc4_doublecrack dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] ct_mem [256];
   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read ct memory: data one cycle after address
   always @(posedge clk) bus.ct_rddata <= ct_mem[bus.ct_addr];

   // Software ARC4: first 256 keystream bytes for a 24-bit key
   function automatic void keystream(input logic [23:0] k, output logic [7:0] ks [256]);
      int s [256];
      int j;
      int t;
      int ii;
      int kb;
      for (int n = 0; n < 256; n++) s[n] = n;
      j = 0;
      for (int n = 0; n < 256; n++) begin
         if (n % 3 == 0) kb = int'(k[23:16]);
         else if (n % 3 == 1) kb = int'(k[15:8]);
         else kb = int'(k[7:0]);
         j = (j + s[n] + kb) % 256;
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      ii = 0;
      j  = 0;
      for (int n = 0; n < 256; n++) begin
         ii = (ii + 1) % 256;
         j  = (j + s[ii]) % 256;
         t = s[ii]; s[ii] = s[j]; s[j] = t;
         ks[n] = 8'(s[(s[ii] + s[j]) % 256]);
      end
   endfunction

   function automatic bit rc4_ok(input logic [23:0] k, input int len);
      logic [7:0] ks [256];
      logic [7:0] pt;
      keystream(k, ks);
      for (int n = 0; n < len; n++) begin
         pt = ct_mem[n + 1] ^ ks[n];
         if (pt < 8'h20 || pt > 8'h7E) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int first_key(input int len, input int limit);
      for (int k = 0; k <= limit; k++) begin
         if (rc4_ok(24'(k), len)) return k;
      end
      return -1;
   endfunction

   task automatic make_ct(input logic [23:0] k, input logic [7:0] msg [$]);
      logic [7:0] ks [256];
      keystream(k, ks);
      ct_mem[0] = 8'(msg.size());
      for (int n = 0; n < msg.size(); n++) ct_mem[n + 1] = msg[n] ^ ks[n];
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rdy(input string tag, input int budget);
      int n;
      n = 0;
      while (bus.rdy !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, " done-in-budget"}, 32'(bus.rdy), 32'd1);
   endtask

   task automatic start_search(input string tag);
      @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      check({tag, " rdy-drop"}, 32'(bus.rdy), 32'd0);
      check({tag, " kv-clear"}, 32'(bus.key_valid), 32'd0);
   endtask

   task automatic search_and_check(input string tag, input int len, input int limit);
      int exp;
      exp = first_key(len, limit);
      start_search(tag);
      wait_rdy(tag, (exp / 2 + 3) * 1200);
      check({tag, " key_valid"}, 32'(bus.key_valid), 32'd1);
      check({tag, " key"}, 32'(bus.key), 32'(exp));
   endtask

   initial begin
      logic [7:0] msg [$];
      logic [23:0] prev_key;
      bit          exp_pass;
      int          len;
      int          k;

      bus.en = 1'b0;
      for (int n = 0; n < 256; n++) ct_mem[n] = 8'h00;

      // Reset for one cycle
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("reset rdy", 32'(bus.rdy), 32'd1);
      check("reset key_valid", 32'(bus.key_valid), 32'd0);
      check("reset key", 32'(bus.key), 32'd0);
      check("reset ct_addr", 32'(bus.ct_addr), 32'd0);

      // "Hi" under even key 0x18, with a stray en pulse while busy
      msg = '{8'h48, 8'h69};
      make_ct(24'h000018, msg);
      k = first_key(2, 24);
      start_search("even");
      @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      check("busy en ignored", 32'(bus.rdy), 32'd0);
      wait_rdy("even", (k / 2 + 3) * 1200);
      check("even key_valid", 32'(bus.key_valid), 32'd1);
      check("even key", 32'(bus.key), 32'(k));

      // Same message under odd key 3 (lane B)
      make_ct(24'h000003, msg);
      search_and_check("odd", 2, 3);

      // Empty message: first candidate passes
      ct_mem[0] = 8'h00;
      search_and_check("empty", 0, 0);

      // Randomized printable messages under small random keys
      for (int r = 0; r < 2; r++) begin
         msg.delete();
         len = $urandom_range(6, 1);
         for (int n = 0; n < len; n++) msg.push_back(8'($urandom_range(126, 32)));
         k = $urandom_range(15, 0);
         make_ct(24'(k), msg);
         search_and_check("random", len, k);
      end

      // Exhaustion: random 255-byte ciphertext, base forced to the last key
      prev_key = bus.key;
      ct_mem[0] = 8'd255;
      for (int n = 1; n < 256; n++) ct_mem[n] = 8'($urandom_range(255, 0));
      exp_pass = rc4_ok(24'hFFFFFF, 255);
      start_search("exhaust");
      repeat (100) @(negedge clk);
      force dut.key_attempt_c1 = 24'hFFFFFF;
      wait_rdy("exhaust", 34000);
      release dut.key_attempt_c1;
      check("exhaust key_valid", 32'(bus.key_valid), 32'(exp_pass));
      check("exhaust key", 32'(bus.key), exp_pass ? 32'hFFFFFF : 32'(prev_key));

      // Reset in the middle of a search
      start_search("midreset");
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset rdy", 32'(bus.rdy), 32'd1);
      check("midreset key_valid", 32'(bus.key_valid), 32'd0);
      check("midreset key", 32'(bus.key), 32'd0);
      check("midreset ct_addr", 32'(bus.ct_addr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
